li_channel_mixer: RTL and testbench

- Sits directly downstream of the log-to-linear table stage.
- Takes its registered sign-magnitude operator samples (one per slot) and converts them to two's complement.
- Accumulates carrier-operator samples over one sample frame into separate melody and rhythm sums, then publishes both as saturated signed words with a one-cycle valid strobe.
- Feeds the audio output / DAC interface.

---
 rtl/li_channel_mixer.sv | 151 +++++++++++++++
 tb/tb_li_channel_mixer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/li_channel_mixer.sv
// Converts sign-magnitude operator samples to two's complement and sums the carriers of one frame
// into melody and rhythm words, published saturated with a one-cycle valid strobe.
module li_channel_mixer #(
   parameter int unsigned SLOTS = 18,
   parameter int unsigned W_OUT = 14,
   parameter int unsigned W_ACC = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_start,
   input  logic                    li_valid,
   input  logic                    li_sign,
   input  logic [8:0]              li_value,
   input  logic                    is_carrier,
   input  logic                    is_rhythm,
   output logic signed [W_OUT-1:0] melody_out,
   output logic signed [W_OUT-1:0] rhythm_out,
   output logic                    out_valid,
   output logic                    overrun
);

   localparam int unsigned CntW = $clog2(SLOTS + 1);
   localparam logic signed [W_ACC-1:0] AccMax = {{(W_ACC - W_OUT + 1){1'b0}}, {(W_OUT - 1){1'b1}}};
   localparam logic signed [W_ACC-1:0] AccMin = ~AccMax;

   typedef enum logic [1:0] {StIdle, StAccum, StPublish} state_e;

   state_e                    state_q, state_d;
   logic signed [W_ACC-1:0]   mel_acc_q, mel_acc_d;
   logic signed [W_ACC-1:0]   rhy_acc_q, rhy_acc_d;
   logic        [CntW-1:0]    cnt_q, cnt_d;
   logic signed [W_OUT-1:0]   melody_q, melody_d;
   logic signed [W_OUT-1:0]   rhythm_q, rhythm_d;
   logic                      out_valid_q, out_valid_d;
   logic                      overrun_q, overrun_d;

   logic signed [W_ACC-1:0]   samp_mag;
   logic signed [W_ACC-1:0]   samp;
   logic signed [W_ACC-1:0]   load_mel;
   logic signed [W_ACC-1:0]   load_rhy;
   logic                      restart;

   function automatic logic signed [W_OUT-1:0] sat(input logic signed [W_ACC-1:0] a);
      logic signed [W_ACC-1:0] c;
      if (a > AccMax) begin
         c = AccMax;
      end else if (a < AccMin) begin
         c = AccMin;
      end else begin
         c = a;
      end
      return c[W_OUT-1:0];
   endfunction

   // Negating a zero magnitude yields zero, so no negative zero can appear.
   always_comb begin
      samp_mag = {{(W_ACC - 9){1'b0}}, li_value};
      samp     = li_sign ? -samp_mag : samp_mag;
      load_mel = (li_valid && is_carrier && !is_rhythm) ? samp : '0;
      load_rhy = (li_valid && is_carrier && is_rhythm) ? samp : '0;
   end

   always_comb begin
      state_d     = state_q;
      mel_acc_d   = mel_acc_q;
      rhy_acc_d   = rhy_acc_q;
      cnt_d       = cnt_q;
      melody_d    = melody_q;
      rhythm_d    = rhythm_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;
      restart     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               restart = 1'b1;
            end
         end
         StAccum: begin
            if (frame_start) begin
               restart   = 1'b1;
               overrun_d = 1'b1;
            end else if (li_valid) begin
               cnt_d = cnt_q + CntW'(1);
               if (is_carrier) begin
                  if (is_rhythm) begin
                     rhy_acc_d = rhy_acc_q + samp;
                  end else begin
                     mel_acc_d = mel_acc_q + samp;
                  end
               end
               if (cnt_d == CntW'(SLOTS)) begin
                  state_d = StPublish;
               end
            end
         end
         StPublish: begin
            melody_d    = sat(mel_acc_q);
            rhythm_d    = sat(rhy_acc_q);
            out_valid_d = 1'b1;
            mel_acc_d   = '0;
            rhy_acc_d   = '0;
            cnt_d       = '0;
            state_d     = StIdle;
            if (frame_start) begin
               restart = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A new frame overrides whatever the current state decided for the accumulators.
      if (restart) begin
         mel_acc_d = load_mel;
         rhy_acc_d = load_rhy;
         cnt_d     = CntW'(li_valid);
         state_d   = (li_valid && (SLOTS == 1)) ? StPublish : StAccum;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         mel_acc_q   <= '0;
         rhy_acc_q   <= '0;
         cnt_q       <= '0;
         melody_q    <= '0;
         rhythm_q    <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mel_acc_q   <= mel_acc_d;
         rhy_acc_q   <= rhy_acc_d;
         cnt_q       <= cnt_d;
         melody_q    <= melody_d;
         rhythm_q    <= rhythm_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign melody_out = melody_q;
   assign rhythm_out = rhythm_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_li_channel_mixer.sv
// Scoreboard bench for li_channel_mixer: a 14-bit and a 13-bit output instance share stimulus,
// expected sums are queued as samples are driven and popped when a publish is captured.
module tb_li_channel_mixer;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_start, li_valid, li_sign, is_carrier, is_rhythm;
   logic [8:0]        li_value;
   logic signed [13:0] melody_out, rhythm_out;
   logic signed [12:0] melody13, rhythm13;
   logic              out_valid, overrun, out_valid13, overrun13;

   li_channel_mixer #(.SLOTS(18), .W_OUT(14), .W_ACC(16)) dut (
      .clk(clk), .reset(rst_n), .frame_start(frame_start), .li_valid(li_valid),
      .li_sign(li_sign), .li_value(li_value), .is_carrier(is_carrier), .is_rhythm(is_rhythm),
      .melody_out(melody_out), .rhythm_out(rhythm_out), .out_valid(out_valid), .overrun(overrun)
   );

   li_channel_mixer #(.SLOTS(18), .W_OUT(13), .W_ACC(16)) dut13 (
      .clk(clk), .reset(rst_n), .frame_start(frame_start), .li_valid(li_valid),
      .li_sign(li_sign), .li_value(li_value), .is_carrier(is_carrier), .is_rhythm(is_rhythm),
      .melody_out(melody13), .rhythm_out(rhythm13), .out_valid(out_valid13),
      .overrun(overrun13)
   );

   always #5 clk = ~clk;

   typedef struct {int mel; int rhy; int mel13; int rhy13;} res_t;
   typedef struct {int mel; int rhy; int mel13; int rhy13; bit v14; bit v13; int cyc;} cap_t;

   res_t exp_q[$];
   cap_t cap_q[$];
   cap_t mon_c;
   int   cycle = 0;
   int   errors = 0;
   int   checks = 0;
   int   m_sum, r_sum;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (out_valid || out_valid13) begin
         mon_c.mel   = int'(melody_out);
         mon_c.rhy   = int'(rhythm_out);
         mon_c.mel13 = int'(melody13);
         mon_c.rhy13 = int'(rhythm13);
         mon_c.v14   = out_valid;
         mon_c.v13   = out_valid13;
         mon_c.cyc   = cycle;
         cap_q.push_back(mon_c);
      end
   end

   function automatic int sat(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      frame_start = 1'b0;
      li_valid    = 1'b0;
      li_sign     = 1'b0;
      li_value    = '0;
      is_carrier  = 1'b0;
      is_rhythm   = 1'b0;
   endtask

   // Sample the DUT must ignore: not added to the model.
   task automatic drive_ignored(input bit sg, input int val, input bit car, input bit rhy);
      li_valid   = 1'b1;
      li_sign    = sg;
      li_value   = val[8:0];
      is_carrier = car;
      is_rhythm  = rhy;
      cyc();
      idle_in();
   endtask

   task automatic send(input bit fs, input bit sg, input int val, input bit car, input bit rhy);
      int s;
      frame_start = fs;
      li_valid    = 1'b1;
      li_sign     = sg;
      li_value    = val[8:0];
      is_carrier  = car;
      is_rhythm   = rhy;
      if (fs) begin
         m_sum = 0;
         r_sum = 0;
      end
      s = sg ? -val : val;
      if (car) begin
         if (rhy) r_sum += s;
         else     m_sum += s;
      end
      cyc();
      idle_in();
   endtask

   task automatic push_exp();
      exp_q.push_back('{sat(m_sum, 14), sat(r_sum, 14), sat(m_sum, 13), sat(r_sum, 13)});
   endtask

   task automatic check_next(input string name, input int bound);
      int   n;
      cap_t c;
      res_t e;
      n = 0;
      while (cap_q.size() == 0 && n < bound) begin
         cyc();
         n++;
      end
      checks++;
      if (cap_q.size() == 0 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no publish within %0d cycles (captured=%0d expected=%0d)",
                  name, bound, cap_q.size(), exp_q.size());
      end else begin
         c = cap_q.pop_front();
         e = exp_q.pop_front();
         checks += 4;
         if (c.mel !== e.mel) begin
            errors++;
            $display("FAIL %s melody: got %0d want %0d", name, c.mel, e.mel);
         end
         if (c.rhy !== e.rhy) begin
            errors++;
            $display("FAIL %s rhythm: got %0d want %0d", name, c.rhy, e.rhy);
         end
         if (c.mel13 !== e.mel13) begin
            errors++;
            $display("FAIL %s melody13: got %0d want %0d", name, c.mel13, e.mel13);
         end
         if (c.rhy13 !== e.rhy13) begin
            errors++;
            $display("FAIL %s rhythm13: got %0d want %0d", name, c.rhy13, e.rhy13);
         end
         checks++;
         if (!(c.v14 && c.v13)) begin
            errors++;
            $display("FAIL %s strobe: got v14=%0b v13=%0b want 1 1", name, c.v14, c.v13);
         end
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if (out_valid !== 1'b0 || out_valid13 !== 1'b0 || melody_out !== 14'sd0 ||
          rhythm_out !== 14'sd0 || overrun !== 1'b0 || overrun13 !== 1'b0 ||
          melody13 !== 13'sd0 || rhythm13 !== 13'sd0) begin
         errors++;
         $display("FAIL %s: got ov=%0b mel=%0d rhy=%0d ovr=%0b want all zero",
                  name, out_valid, melody_out, rhythm_out, overrun);
      end
   endtask

   task automatic test_reset();
      idle_in();
      rst_n = 1'b0;
      repeat (3) cyc();
      check_quiet("reset_asserted");
      rst_n = 1'b1;
      cyc();
      check_quiet("reset_released");
   endtask

   task automatic test_basic();
      drive_ignored(1'b0, 200, 1'b1, 1'b0);
      drive_ignored(1'b0, 300, 1'b1, 1'b1);
      send(1'b1, 1'b0, 100, 1'b1, 1'b0);
      for (int i = 1; i < 18; i++) send(1'b0, 1'b0, 100, 1'b1, 1'b0);
      push_exp();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: out_valid got %0b want 0", out_valid);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || melody_out !== 14'sd1800) begin
         errors++;
         $display("FAIL latency_pulse: got ov=%0b mel=%0d want 1 1800", out_valid, melody_out);
      end
      check_next("basic", 4);
      repeat (3) cyc();
      checks++;
      if (out_valid !== 1'b0 || melody_out !== 14'sd1800 || rhythm_out !== 14'sd0) begin
         errors++;
         $display("FAIL hold: got ov=%0b mel=%0d rhy=%0d want 0 1800 0",
                  out_valid, melody_out, rhythm_out);
      end
   endtask

   task automatic test_modulators();
      for (int i = 0; i < 18; i++) begin
         if (i % 2 == 0) send(i == 0, 1'b0, 511, 1'b1, 1'b0);
         else            send(1'b0, 1'b0, 511, 1'b0, i % 4 == 1);
      end
      push_exp();
      // Lands in the publish cycle without frame_start.
      drive_ignored(1'b0, 511, 1'b1, 1'b0);
      check_next("modulators", 4);
   endtask

   task automatic test_rhythm();
      for (int i = 0; i < 18; i++) begin
         if (i < 5)       send(i == 0, 1'b1, 300, 1'b1, 1'b1);
         else if (i == 5) send(1'b0, 1'b1, 0, 1'b1, 1'b0);
         else             send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      end
      push_exp();
      check_next("rhythm_neg", 4);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 18; i++) send(i == 0, 1'b0, 511, 1'b1, 1'b0);
      push_exp();
      check_next("sat_pos", 4);
      for (int i = 0; i < 18; i++) send(i == 0, 1'b1, 511, 1'b1, 1'b0);
      push_exp();
      check_next("sat_neg", 4);
      for (int i = 0; i < 18; i++) send(i == 0, 1'b1, 511, 1'b1, 1'b1);
      push_exp();
      check_next("sat_neg_rhythm", 4);
   endtask

   task automatic test_overrun();
      send(1'b1, 1'b0, 50, 1'b1, 1'b0);
      for (int i = 1; i < 10; i++) send(1'b0, 1'b0, 50, 1'b1, i % 2 == 1);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_early: got %0b want 0", overrun);
      end
      send(1'b1, 1'b0, 7, 1'b1, 1'b0);
      checks++;
      if (overrun !== 1'b1 || overrun13 !== 1'b1 || cap_q.size() != 0) begin
         errors++;
         $display("FAIL overrun_set: got %0b pulses=%0d want 1 0", overrun, cap_q.size());
      end
      for (int i = 1; i < 18; i++) send(1'b0, 1'b0, (i < 6) ? 3 : 7, 1'b1, i < 6);
      push_exp();
      check_next("after_overrun", 4);
      repeat (5) cyc();
      checks++;
      if (overrun !== 1'b1 || cap_q.size() != 0) begin
         errors++;
         $display("FAIL overrun_sticky: got %0b extra=%0d want 1 0", overrun, cap_q.size());
      end
   endtask

   task automatic test_back_to_back();
      cap_t a, b;
      for (int i = 0; i < 18; i++) send(i == 0, 1'b0, 20, 1'b1, 1'b1);
      push_exp();
      // Frame B starts in A's publish cycle, so its 18 samples end SLOTS cycles after A's.
      send(1'b1, 1'b0, 500, 1'b1, 1'b0);
      for (int i = 1; i < 18; i++) send(1'b0, 1'b0, 1, 1'b1, 1'b0);
      push_exp();
      repeat (3) cyc();
      checks++;
      if (cap_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses want 2", cap_q.size());
      end else begin
         a = cap_q[0];
         b = cap_q[1];
         checks++;
         if (b.cyc - a.cyc != 18) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want 18", b.cyc - a.cyc);
         end
      end
      check_next("b2b_first", 2);
      check_next("b2b_second", 2);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 18; i++) send(i == 0, 1'b0, 30, 1'b1, 1'b0);
      cyc();
      #2 rst_n = 1'b0;
      #1 check_quiet("reset_during_pulse");
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 8; i++) send(i == 0, 1'b0, 40, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_quiet("reset_mid_frame");
      cyc();
      rst_n = 1'b1;
      repeat (25) cyc();
      check_quiet("no_publish_after_reset");
      checks++;
      if (cap_q.size() != 0) begin
         errors++;
         $display("FAIL spurious_pulse: got %0d pulses want 0", cap_q.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_modulators();
      test_rhythm();
      test_saturation();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
